rf_port_ctrl: RTL and testbench

Port controller and arbiter for the 32x32-bit dual-read/single-write CPU register file. After reset it clears all 32 entries, then serves the core pipeline and a host debug port. The core pipeline reads through both read ports and writes back through the single write port. The debug port is granted a slot only when the core leaves one free, with a starvation guard that forces a one-cycle core stall. Entry 0 is hard-wired to zero (x0 semantics).

---
 rtl/rf_ctrl_pkg.sv | 9 +
 rtl/dprf_32x32bit.sv | 22 ++
 rtl/rf_port_ctrl.sv | 137 +++++++++++++
 tb/tb_rf_port_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file port controller: FSM states, address and data types.
package rf_ctrl_pkg;
    localparam int RF_DEPTH = 32;

    typedef logic [6:2]  rf_addr_t;
    typedef logic [31:0] rf_data_t;

    typedef enum logic [1:0] {INIT, RUN, FORCE, ACK} rf_state_e;
endpackage

// File: rtl/dprf_32x32bit.sv
// 32x32 register file storage: one synchronous write port, two combinational read ports.
module dprf_32x32bit
    import rf_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     we,
    input  rf_addr_t waddr,
    input  rf_data_t wdata,
    input  rf_addr_t raddr1,
    output rf_data_t rdata1,
    input  rf_addr_t raddr2,
    output rf_data_t rdata2
);
    rf_data_t mem_q [RF_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];
endmodule

// File: rtl/rf_port_ctrl.sv
// Register-file port controller: post-reset clear, core access, debug arbitration with starvation guard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module rf_port_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 16
) (
    input  logic     clk,
    input  logic     srst_n,
    output logic     init_done,
    output logic     core_stall,
    input  rf_addr_t rs1_addr,
    output rf_data_t rs1_data,
    input  logic     rs2_en,
    input  rf_addr_t rs2_addr,
    output rf_data_t rs2_data,
    input  logic     wb_en,
    input  rf_addr_t wb_addr,
    input  rf_data_t wb_data,
    input  logic     dbg_req,
    input  logic     dbg_we,
    input  rf_addr_t dbg_addr,
    input  rf_data_t dbg_wdata,
    output logic     dbg_ack,
    output rf_data_t dbg_rdata
);
    localparam logic [7:0] WAIT_LIM = 8'(STARVE_MAX - 1);

    rf_state_e  state_q, state_d;
    rf_addr_t   cnt_q, cnt_d;
    logic [7:0] wait_q, wait_d;
    logic       ack_q, ack_d;
    rf_data_t   rdata_q, rdata_d;

    logic       slot_free, dbg_go, dbg_rd;
    logic       wr_en, rf_we;
    rf_addr_t   wr_addr, raddr2;
    rf_data_t   wr_data, rd1, rd2, port2_data;

    // A debug access takes the slot the core leaves idle, or both slots when forced.
    assign slot_free = dbg_we ? ~wb_en : ~rs2_en;
    assign dbg_go    = (state_q == FORCE) | ((state_q == RUN) & dbg_req & slot_free);
    assign dbg_rd    = dbg_go & ~dbg_we;
    assign raddr2    = dbg_rd ? dbg_addr : rs2_addr;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wb_addr;
        wr_data = wb_data;
        if (state_q == INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
        end else if (dbg_go & dbg_we) begin
            wr_en   = (dbg_addr != '0);
            wr_addr = dbg_addr;
            wr_data = dbg_wdata;
        end else if (state_q != FORCE) begin
            wr_en   = wb_en & (wb_addr != '0);
        end
    end

    // Storage must not see a write while reset is held.
    assign rf_we = wr_en & srst_n;

    dprf_32x32bit u_rf (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .raddr1 (rs1_addr),
        .rdata1 (rd1),
        .raddr2 (raddr2),
        .rdata2 (rd2)
    );

`ifdef RF_BYPASS_EN
    assign rs1_data   = (rf_we & (wr_addr != '0) & (wr_addr == rs1_addr)) ? wr_data :
                        (rs1_addr == '0) ? '0 : rd1;
    assign port2_data = (rf_we & (wr_addr != '0) & (wr_addr == raddr2)) ? wr_data :
                        (raddr2 == '0) ? '0 : rd2;
`else
    assign rs1_data   = (rs1_addr == '0) ? '0 : rd1;
    assign port2_data = (raddr2 == '0) ? '0 : rd2;
`endif
    assign rs2_data   = port2_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        ack_d   = dbg_go;
        rdata_d = dbg_rd ? port2_data : rdata_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = RUN;
            end
            RUN: begin
                if (dbg_go) begin
                    state_d = ACK;
                    wait_d  = '0;
                end else if (dbg_req) begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q + 8'd1 == WAIT_LIM) state_d = FORCE;
                end
            end
            FORCE: begin
                state_d = ACK;
                wait_d  = '0;
            end
            ACK:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            wait_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign init_done  = (state_q != INIT);
    assign core_stall = ~init_done | (state_q == FORCE);
    assign dbg_ack    = ack_q;
    assign dbg_rdata  = rdata_q;
endmodule

// File: tb/tb_rf_port_ctrl.sv
// Directed self-checking bench for rf_port_ctrl (STARVE_MAX=4).
module tb_rf_port_ctrl;
    import rf_ctrl_pkg::*;

    logic     clk = 1'b0;
    logic     srst_n;
    logic     init_done, core_stall;
    rf_addr_t rs1_addr, rs2_addr, wb_addr, dbg_addr;
    rf_data_t rs1_data, rs2_data, wb_data, dbg_wdata, dbg_rdata;
    logic     rs2_en, wb_en, dbg_req, dbg_we, dbg_ack;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rf_port_ctrl #(.STARVE_MAX(4)) dut (
        .clk(clk), .srst_n(srst_n), .init_done(init_done), .core_stall(core_stall),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_en(rs2_en), .rs2_addr(rs2_addr),
        .rs2_data(rs2_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_en = 0; wb_addr = '0; wb_data = '0;
        rs2_en = 0; rs1_addr = '0; rs2_addr = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic core_write(input int a, input rf_data_t d);
        wb_en = 1; wb_addr = 5'(a); wb_data = d;
        tick();
        wb_en = 0;
    endtask

    task automatic test_reset();
        int n;
        srst_n = 0;
        tick(); tick();
        tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL reset_init_done got %b exp 0", init_done); end
        tests++; if (core_stall !== 1'b1) begin fails++; $display("FAIL reset_stall got %b exp 1", core_stall); end
        tests++; if (dbg_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b exp 0", dbg_ack); end
        tests++; if (dbg_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", dbg_rdata); end
        srst_n = 1;
        n = 0;
        while (!init_done && n < 100) begin tick(); n++; end
        tests++; if (n !== 32) begin fails++; $display("FAIL reset_init_len got %0d exp 32", n); end
    endtask

    task automatic test_clear();
        int n, bad_stall;
        for (int i = 1; i < 32; i++) core_write(i, 32'hF00D_0000 + 32'(i));
        rs1_addr = 5'd3; #1;
        tests++; if (rs1_data !== 32'hF00D_0003) begin fails++; $display("FAIL clear_preload got %h exp f00d0003", rs1_data); end
        srst_n = 0;
        tick(); tick();
        srst_n = 1;
        n = 0; bad_stall = 0;
        while (!init_done && n < 100) begin
            if (core_stall !== 1'b1) bad_stall++;
            tick(); n++;
        end
        tests++; if (n !== 32) begin fails++; $display("FAIL clear_len got %0d exp 32", n); end
        tests++; if (bad_stall !== 0) begin fails++; $display("FAIL clear_stall got %0d unstalled cycles exp 0", bad_stall); end
        tests++; if (core_stall !== 1'b0) begin fails++; $display("FAIL clear_stall_after got %b exp 0", core_stall); end
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a); #1;
            tests++; if (rs1_data !== 32'h0) begin fails++; $display("FAIL clear_entry%0d got %h exp 0", a, rs1_data); end
        end
    endtask

    task automatic test_dbg_write();
        wb_en = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 5'd5; dbg_wdata = 32'h1234_5678;
        #1;
        tests++; if (dbg_ack !== 1'b0) begin fails++; $display("FAIL dbgwr_ack_early got %b exp 0", dbg_ack); end
        tick();
        tests++; if (dbg_ack !== 1'b1) begin fails++; $display("FAIL dbgwr_ack got %b exp 1", dbg_ack); end
        dbg_req = 0; dbg_we = 0;
        rs1_addr = 5'd5; #1;
        tests++; if (rs1_data !== 32'h1234_5678) begin fails++; $display("FAIL dbgwr_data got %h exp 12345678", rs1_data); end
        tick();
        tests++; if (dbg_ack !== 1'b0) begin fails++; $display("FAIL dbgwr_ack_pulse got %b exp 0", dbg_ack); end
    endtask

    task automatic test_x0();
        core_write(0, 32'hDEAD_BEEF);
        rs1_addr = '0; #1;
        tests++; if (rs1_data !== 32'h0) begin fails++; $display("FAIL x0_core got %h exp 0", rs1_data); end
        // Debug read of a nonzero entry first so a stuck dbg_rdata cannot pass the x0 read.
        rs2_en = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 5'd5;
        tick();
        dbg_req = 0;
        tests++; if (dbg_rdata !== 32'h1234_5678) begin fails++; $display("FAIL dbgrd_5 got %h exp 12345678", dbg_rdata); end
        tick();
        dbg_req = 1; dbg_addr = '0;
        tick();
        dbg_req = 0;
        tests++; if (dbg_ack !== 1'b1) begin fails++; $display("FAIL x0_dbg_ack got %b exp 1", dbg_ack); end
        tests++; if (dbg_rdata !== 32'h0) begin fails++; $display("FAIL x0_dbg got %h exp 0", dbg_rdata); end
        tick();
    endtask

    task automatic test_forced_grant();
        int stalls, stall_at, ack_early;
        core_write(7, 32'hA5A5_A5A5);
        rs2_en = 1; rs2_addr = 5'd1; dbg_req = 1; dbg_we = 0; dbg_addr = 5'd7;
        stalls = 0; stall_at = 0; ack_early = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (core_stall) begin stalls++; stall_at = k; end
            if (dbg_ack) ack_early++;
            tick();
        end
        dbg_req = 0;
        tests++; if (stalls !== 1) begin fails++; $display("FAIL force_stall_cnt got %0d exp 1", stalls); end
        tests++; if (stall_at !== 4) begin fails++; $display("FAIL force_stall_cycle got %0d exp 4", stall_at); end
        tests++; if (ack_early !== 0) begin fails++; $display("FAIL force_ack_early got %0d exp 0", ack_early); end
        tests++; if (dbg_ack !== 1'b1) begin fails++; $display("FAIL force_ack got %b exp 1", dbg_ack); end
        tests++; if (dbg_rdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL force_rdata got %h exp a5a5a5a5", dbg_rdata); end
        tests++; if (core_stall !== 1'b0) begin fails++; $display("FAIL force_stall_ack got %b exp 0", core_stall); end
        rs2_en = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        dbg_req = 1; dbg_we = 1; dbg_addr = 5'd10; dbg_wdata = 32'h0000_0A0A;
        tick();
        tests++; if (dbg_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack1 got %b exp 1", dbg_ack); end
        // New request presented during ACK; it cannot be granted until RUN.
        dbg_addr = 5'd11; dbg_wdata = 32'h0000_0B0B;
        tick();
        tests++; if (dbg_ack !== 1'b0) begin fails++; $display("FAIL b2b_gap got %b exp 0", dbg_ack); end
        tick();
        tests++; if (dbg_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack2 got %b exp 1", dbg_ack); end
        dbg_req = 0; dbg_we = 0;
        rs1_addr = 5'd11; #1;
        tests++; if (rs1_data !== 32'h0000_0B0B) begin fails++; $display("FAIL b2b_data got %h exp 00000b0b", rs1_data); end
        tick();
    endtask

    task automatic test_bypass();
        rf_data_t exp0;
        core_write(9, 32'h1111_1111);
`ifdef RF_BYPASS_EN
        exp0 = 32'hCAFE_F00D;
`else
        exp0 = 32'h1111_1111;
`endif
        wb_en = 1; wb_addr = 5'd9; wb_data = 32'hCAFE_F00D; rs2_en = 1; rs2_addr = 5'd9;
        #1;
        tests++; if (rs2_data !== exp0) begin fails++; $display("FAIL bypass_same got %h exp %h", rs2_data, exp0); end
        tick();
        wb_en = 0; #1;
        tests++; if (rs2_data !== 32'hCAFE_F00D) begin fails++; $display("FAIL bypass_next got %h exp cafef00d", rs2_data); end
        rs2_en = 0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        int k, n, acks;
        core_write(12, 32'h0BAD_C0DE);
        rs2_en = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 5'd12;
        k = 0;
        #1;
        while (!core_stall && k < 10) begin tick(); k++; end
        tests++; if (core_stall !== 1'b1) begin fails++; $display("FAIL midrst_force got %b exp 1", core_stall); end
        srst_n = 0;
        acks = 0;
        tick(); if (dbg_ack) acks++;
        dbg_req = 0; rs2_en = 0;
        tick(); if (dbg_ack) acks++;
        srst_n = 1;
        n = 0;
        while (!init_done && n < 100) begin
            tick(); n++;
            if (dbg_ack) acks++;
        end
        for (int i = 0; i < 4; i++) begin tick(); if (dbg_ack) acks++; end
        tests++; if (n !== 32) begin fails++; $display("FAIL midrst_len got %0d exp 32", n); end
        tests++; if (acks !== 0) begin fails++; $display("FAIL midrst_ack got %0d acks exp 0", acks); end
        rs1_addr = 5'd12; #1;
        tests++; if (rs1_data !== 32'h0) begin fails++; $display("FAIL midrst_entry got %h exp 0", rs1_data); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        srst_n = 0;
        test_reset();
        test_clear();
        test_dbg_write();
        test_x0();
        test_forced_grant();
        test_back_to_back();
        test_bypass();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
